lc3_regfile: RTL and testbench

- Architectural register file (R0-R7) plus condition-code (NZP) and branch-enable (BEN) state for the LC-3 datapath.
- Sits directly upstream of the ALU, supplying sr1out/sr2out.
- Captures results from the shared 16-bit data bus on ld_reg/ld_cc, giving the ALU its write-back and flag-update path.
- Driven by the control FSM's ld_reg, ld_cc, ld_ben, drmux and sr1mux signals.

---
 rtl/lc3_pkg.sv | 28 ++
 rtl/lc3_cc_logic.sv | 60 ++++++
 rtl/lc3_regfile.sv | 113 +++++++++++
 tb/tb_lc3_regfile.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 register file slice.
// Holds the bus width, the destination/SR1 select encodings, the fixed
// subroutine/stack register indices and the condition-code reset value.
package lc3_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    DR_IR11_9 = 2'b00,
    DR_R7     = 2'b01,
    DR_R6     = 2'b10,
    DR_RSVD   = 2'b11
  } drmux_e;

  typedef enum logic [1:0] {
    SR1_IR11_9 = 2'b00,
    SR1_IR8_6  = 2'b01,
    SR1_R6     = 2'b10,
    SR1_RSVD   = 2'b11
  } sr1mux_e;

  localparam logic [2:0] R6_IDX = 3'd6;
  localparam logic [2:0] R7_IDX = 3'd7;

  // {n,z,p} after reset: Z set
  localparam logic [2:0] CC_RST_DEF = 3'b010;

endpackage

// File: rtl/lc3_cc_logic.sv
// Condition-code (NZP) and branch-enable (BEN) registers for the LC-3.
// BEN is always evaluated against the NZP value held before the edge, so a
// simultaneous CC load never feeds into the branch decision of the same edge.
module lc3_cc_logic
  import lc3_pkg::*;
#(
  parameter int         DW     = DATA_W,
  parameter logic [2:0] CC_RST = CC_RST_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] data_bus,
  input  logic [2:0]    ir_11_9,
  input  logic          ld_cc,
  input  logic          ld_ben,
  output logic          n,
  output logic          z,
  output logic          p,
  output logic          ben
);

  logic [2:0] nzp_q, nzp_d;
  logic       ben_q, ben_d;
  logic       bus_zero;

  assign bus_zero = (data_bus == '0);

  // Next-state for the flags: classify the bus word as negative/zero/positive
  always_comb begin
    nzp_d = nzp_q;
    ben_d = ben_q;
    if (ld_cc) begin
      nzp_d[2] = data_bus[DW-1];
      nzp_d[1] = bus_zero;
      nzp_d[0] = !data_bus[DW-1] && !bus_zero;
    end
    if (ld_ben) begin
      ben_d = (ir_11_9[2] & nzp_q[2]) |
              (ir_11_9[1] & nzp_q[1]) |
              (ir_11_9[0] & nzp_q[0]);
    end
  end

  // Flag registers with asynchronous reset to the configured CC value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzp_q <= CC_RST;
      ben_q <= 1'b0;
    end else begin
      nzp_q <= nzp_d;
      ben_q <= ben_d;
    end
  end

  assign n   = nzp_q[2];
  assign z   = nzp_q[1];
  assign p   = nzp_q[0];
  assign ben = ben_q;

endmodule

// File: rtl/lc3_regfile.sv
// LC-3 architectural register file R0-R7 with NZP/BEN state.
// Reads are purely combinational from the stored array (no bus bypass), so a
// write becomes visible only after the edge that performs it.
// Optional third read port for debug is enabled by defining LC3_REG_DBG_EN.
module lc3_regfile
  import lc3_pkg::*;
#(
  parameter int         DATA_W = lc3_pkg::DATA_W,
  parameter logic [2:0] CC_RST = CC_RST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       ir,
  input  logic [DATA_W-1:0] data_bus,
  input  logic              ld_reg,
  input  logic [1:0]        drmux,
  input  logic [1:0]        sr1mux,
  input  logic              ld_cc,
  input  logic              ld_ben,
  output logic [DATA_W-1:0] sr1out,
  output logic [DATA_W-1:0] sr2out,
  output logic              n,
  output logic              z,
  output logic              p,
  output logic              ben
`ifdef LC3_REG_DBG_EN
  ,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
`else
  // architectural interface only
`endif
);

  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];
  logic [2:0]        dr_idx;
  logic              dr_en;
  logic [2:0]        sr1_idx;
  logic              unused_ir;

  // Opcode and immediate bits are decoded elsewhere in the datapath
  assign unused_ir = ^{ir[15:12], ir[5:3]};

  // Destination decode; the reserved code turns the write off entirely
  always_comb begin
    dr_idx = ir[11:9];
    dr_en  = 1'b1;
    case (drmux_e'(drmux))
      DR_IR11_9: dr_idx = ir[11:9];
      DR_R7:     dr_idx = R7_IDX;
      DR_R6:     dr_idx = R6_IDX;
      default: begin
        dr_idx = ir[11:9];
        dr_en  = 1'b0;
      end
    endcase
  end

  // SR1 decode; the reserved code aliases the ir[11:9] selection
  always_comb begin
    sr1_idx = ir[11:9];
    case (sr1mux_e'(sr1mux))
      SR1_IR8_6: sr1_idx = ir[8:6];
      SR1_R6:    sr1_idx = R6_IDX;
      default:   sr1_idx = ir[11:9];
    endcase
  end

  // Next array contents: only the decoded destination takes the bus word
  always_comb begin
    regs_d = regs_q;
    if (ld_reg && dr_en) begin
      regs_d[dr_idx] = data_bus;
    end
  end

  // Register array with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign sr1out = regs_q[sr1_idx];
  assign sr2out = regs_q[ir[2:0]];

`ifdef LC3_REG_DBG_EN
  assign dbg_data = regs_q[dbg_sel];
`else
`endif

  lc3_cc_logic #(
    .DW     (DATA_W),
    .CC_RST (CC_RST)
  ) u_cc (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_bus (data_bus),
    .ir_11_9  (ir[11:9]),
    .ld_cc    (ld_cc),
    .ld_ben   (ld_ben),
    .n        (n),
    .z        (z),
    .p        (p),
    .ben      (ben)
  );

endmodule

// File: tb/tb_lc3_regfile.sv
// Self-checking bench for lc3_regfile: directed cases followed by random
// traffic compared against an array-based reference model of the register
// file and flags.
module tb_lc3_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] ir = '0;
  logic [15:0] data_bus = '0;
  logic        ld_reg = 1'b0;
  logic [1:0]  drmux = '0;
  logic [1:0]  sr1mux = '0;
  logic        ld_cc = 1'b0;
  logic        ld_ben = 1'b0;
  logic [15:0] sr1out, sr2out;
  logic        n, z, p, ben;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] m_regs [8];
  logic        m_n, m_z, m_p, m_ben;

  lc3_regfile dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ir       (ir),
    .data_bus (data_bus),
    .ld_reg   (ld_reg),
    .drmux    (drmux),
    .sr1mux   (sr1mux),
    .ld_cc    (ld_cc),
    .ld_ben   (ld_ben),
    .sr1out   (sr1out),
    .sr2out   (sr2out),
    .n        (n),
    .z        (z),
    .p        (p),
    .ben      (ben)
  );

  // free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] mkIr(input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] c);
    return {4'b0000, a, b, 3'b000, c};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_n = 1'b0; m_z = 1'b1; m_p = 1'b0;
    m_ben = 1'b0;
  endtask

  function automatic logic [15:0] modelSr1();
    case (sr1mux)
      2'd1:    return m_regs[ir[8:6]];
      2'd2:    return m_regs[6];
      default: return m_regs[ir[11:9]];
    endcase
  endfunction

  // drive one cycle of controls, clock it, and advance the model
  task automatic applyStimulus(input logic [15:0] ir_v, input logic [15:0] bus_v,
                               input logic ld_reg_v, input logic [1:0] dr_v,
                               input logic [1:0] sr1_v, input logic ld_cc_v,
                               input logic ld_ben_v);
    logic       next_ben;
    logic       we;
    logic [2:0] dr;
    ir = ir_v; data_bus = bus_v; ld_reg = ld_reg_v; drmux = dr_v;
    sr1mux = sr1_v; ld_cc = ld_cc_v; ld_ben = ld_ben_v;
    next_ben = (ir_v[11] && m_n) || (ir_v[10] && m_z) || (ir_v[9] && m_p);
    we = ld_reg_v;
    case (dr_v)
      2'd0:    dr = ir_v[11:9];
      2'd1:    dr = 3'd7;
      2'd2:    dr = 3'd6;
      default: begin dr = 3'd0; we = 1'b0; end
    endcase
    @(posedge clk);
    #1;
    if (we) m_regs[dr] = bus_v;
    if (ld_cc_v) begin
      m_n = (bus_v >= 16'h8000);
      m_z = (bus_v == 16'h0000);
      m_p = (bus_v != 16'h0000) && (bus_v < 16'h8000);
    end
    if (ld_ben_v) m_ben = next_ben;
    ld_reg = 1'b0; ld_cc = 1'b0; ld_ben = 1'b0;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".sr1out"}, sr1out, modelSr1());
    checkOutput({tag, ".sr2out"}, sr2out, m_regs[ir[2:0]]);
    checkOutput({tag, ".nzp"}, {13'b0, n, z, p}, {13'b0, m_n, m_z, m_p});
    checkOutput({tag, ".ben"}, {15'b0, ben}, {15'b0, m_ben});
  endtask

  // read every register through both ports without clocking
  task automatic sweepReads(input string tag);
    for (int i = 0; i < 8; i++) begin
      ir = mkIr(i[2:0], 3'(7 - i), i[2:0]);
      sr1mux = 2'd0;
      #1;
      checkOutput({tag, ".sr1"}, sr1out, m_regs[i]);
      checkOutput({tag, ".sr2"}, sr2out, m_regs[i]);
      sr1mux = 2'd1;
      #1;
      checkOutput({tag, ".sr1b"}, sr1out, m_regs[7 - i]);
    end
  endtask

  // reset asserted between edges while a write and a CC load are pending
  task automatic resetPulse(input string tag, input logic [15:0] ir_v);
    ir = ir_v; sr1mux = 2'd0;
    ld_reg = 1'b1; drmux = 2'd0; ld_cc = 1'b1; ld_ben = 1'b1;
    data_bus = 16'h8001;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput({tag, ".sr1"}, sr1out, 16'h0000);
    checkOutput({tag, ".sr2"}, sr2out, 16'h0000);
    checkOutput({tag, ".nzp"}, {13'b0, n, z, p}, 16'h0002);
    checkOutput({tag, ".ben"}, {15'b0, ben}, 16'h0000);
    @(negedge clk);
    ld_reg = 1'b0; ld_cc = 1'b0; ld_ben = 1'b0;
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    modelReset();
    #1 rst_n = 1'b0;
    #1;
    sweepReads("rst");
    checkOutput("rst.nzp", {13'b0, n, z, p}, 16'h0002);
    checkOutput("rst.ben", {15'b0, ben}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // write R3 and read it back through both ports
    applyStimulus(mkIr(3'd3, 3'd0, 3'd3), 16'h1234, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("wr.sr1", sr1out, 16'h1234);
    checkOutput("wr.sr2", sr2out, 16'h1234);
    for (int i = 0; i < 8; i++) begin
      ir = mkIr(3'd0, 3'd0, i[2:0]);
      #1;
      checkOutput("wr.other", sr2out, (i == 3) ? 16'h1234 : 16'h0000);
    end

    // sign boundaries of the condition codes
    applyStimulus(16'h0000, 16'h8000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("cc.8000", {13'b0, n, z, p}, 16'h0004);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("cc.0000", {13'b0, n, z, p}, 16'h0002);
    applyStimulus(16'h0000, 16'h7FFF, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("cc.7fff", {13'b0, n, z, p}, 16'h0001);
    applyStimulus(16'h0000, 16'hFFFF, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("cc.ffff", {13'b0, n, z, p}, 16'h0004);

    // fixed destinations and reserved codes
    applyStimulus(mkIr(3'd0, 3'd0, 3'd7), 16'hBEEF, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0);
    checkOutput("dr.r7", sr2out, 16'hBEEF);
    applyStimulus(mkIr(3'd1, 3'd0, 3'd6), 16'hFE00, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0);
    checkOutput("dr.r6", sr2out, 16'hFE00);
    checkOutput("sr1.r6", sr1out, 16'hFE00);
    applyStimulus(mkIr(3'd3, 3'd0, 3'd0), 16'h5555, 1'b1, 2'd3, 2'd3, 1'b0, 1'b0);
    checkOutput("sr1.rsvd", sr1out, 16'h1234);
    sweepReads("dr.rsvd");

    // BEN samples the flags held before the edge
    applyStimulus(mkIr(3'b001, 3'd0, 3'd0), 16'h7FFF, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    applyStimulus(mkIr(3'b001, 3'd0, 3'd0), 16'h0000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    checkOutput("ben.set", {15'b0, ben}, 16'h0001);
    checkOutput("ben.nzp", {13'b0, n, z, p}, 16'h0002);
    applyStimulus(mkIr(3'b001, 3'd0, 3'd0), 16'h0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    checkOutput("ben.clr", {15'b0, ben}, 16'h0000);

    // async reset mid-write after R2 holds a value and CC is negative
    applyStimulus(mkIr(3'd2, 3'd0, 3'd2), 16'h00AA, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(mkIr(3'd2, 3'd0, 3'd2), 16'h8000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("r2.pre", sr1out, 16'h00AA);
    checkOutput("r2.nzp", {13'b0, n, z, p}, 16'h0004);
    resetPulse("arst", mkIr(3'd2, 3'd0, 3'd2));

    // random traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      logic [15:0] bus_r;
      case ($urandom_range(0, 3))
        0:       bus_r = 16'h0000;
        1:       bus_r = 16'h8000;
        default: bus_r = 16'($urandom);
      endcase
      applyStimulus(16'($urandom), bus_r, 1'($urandom), 2'($urandom),
                    2'($urandom), 1'($urandom), 1'($urandom));
      checkModel("rnd");
      if ((k % 97) == 96) begin
        resetPulse("rnd.arst", 16'($urandom));
      end
    end
    sweepReads("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
